// File: rtl/image_dump_uart_tx_pkg.sv
// Shared definitions for the image byte path: FSM state encodings, UART frame shape,
// and the baud counter sizing helper used by both the TX block and the future RX/loader.
package image_dump_uart_tx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Counter must hold CLKS_PER_BIT-1; never narrower than one bit.
    function automatic int baud_cnt_w(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/image_dump_uart_tx_baud_timer.sv
// Bit-period timer: counts clk cycles and emits a 1-cycle tick as each bit period ends.
// restart holds the count at zero so the next period begins exactly on the following edge.
module baud_timer
    import image_dump_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = !restart && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/image_dump_uart_tx.sv
// Streams a block of image bytes from the data memory out of a UART line as 8N1 frames.
// Owns the memory read port: one read per byte, two idle-high cycles between frames.
module image_dump_uart_tx
    import image_dump_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_dout,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [7:0]        shreg;
    logic [2:0]        bit_idx;
    logic              baud_restart;
    logic              bit_tick;

    // The timer only runs while a frame is on the line; everywhere else it is held at zero.
    assign baud_restart = !(state == ST_START || state == ST_DATA || state == ST_STOP);
    assign busy         = (state != ST_IDLE);

    baud_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (baud_restart),
        .tick    (bit_tick)
    );

    // Shift register is pure datapath; it is loaded before use, so no reset is needed.
    always_ff @(posedge clk) begin
        if (state == ST_WAIT) begin
            shreg <= mem_dout;
        end else if (bit_tick && (state == ST_START || state == ST_DATA)) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            remaining  <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            done       <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            byte_count <= '0;
        end else begin
            done   <= 1'b0;
            mem_re <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                tx    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            byte_count <= '0;
                            if (length != '0) begin
                                addr      <= base_addr;
                                remaining <= length;
                                mem_re    <= 1'b1;
                                mem_addr  <= base_addr;
                                state     <= ST_FETCH;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: state <= ST_WAIT;
                    ST_WAIT: begin
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                    ST_START: begin
                        if (bit_tick) begin
                            tx      <= shreg[0];
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_tick) begin
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                tx      <= 1'b1;
                                bit_idx <= '0;
                                state   <= ST_STOP;
                            end else begin
                                tx      <= shreg[0];
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (bit_tick) begin
                            if (bit_idx != 3'(STOP_BITS - 1)) begin
                                bit_idx <= bit_idx + 3'd1;
                            end else begin
                                bit_idx    <= '0;
                                byte_count <= byte_count + (ADDR_W+1)'(1);
                                addr       <= addr + ADDR_W'(1);
                                remaining  <= remaining - (ADDR_W+1)'(1);
                                if (remaining == (ADDR_W+1)'(1)) begin
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end else begin
                                    mem_re   <= 1'b1;
                                    mem_addr <= addr + ADDR_W'(1);
                                    state    <= ST_FETCH;
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_dump_uart_tx.sv
// Bench for image_dump_uart_tx: a fast instance (4 clk/bit) against a cycle-level frame model,
// and a 434 clk/bit instance decoded by a UART line monitor.
module tb_image_dump_uart_tx;

    localparam int CPB      = 4;
    localparam int CPB_S    = 434;
    localparam int BYTE_CYC = 2 + 10 * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] base_addr = '0;
    logic [16:0] length = '0;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_dout;
    logic        tx, busy, done;
    logic [16:0] byte_count;

    logic        start_s = 1'b0, abort_s = 1'b0;
    logic [15:0] base_addr_s = '0;
    logic [16:0] length_s = '0;
    logic [15:0] mem_addr_s;
    logic        mem_re_s;
    logic [7:0]  mem_dout_s;
    logic        tx_s, busy_s, done_s;
    logic [16:0] byte_count_s;

    logic [7:0] mem   [0:65535];
    logic [7:0] mem_s [0:65535];

    // Synchronous BRAM models; outside a read the output is scrambled to prove it is ignored.
    always @(posedge clk) mem_dout   <= mem_re   ? mem[mem_addr]     : 8'($urandom);
    always @(posedge clk) mem_dout_s <= mem_re_s ? mem_s[mem_addr_s] : 8'($urandom);

    image_dump_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
        .length(length), .mem_addr(mem_addr), .mem_re(mem_re), .mem_dout(mem_dout),
        .tx(tx), .busy(busy), .done(done), .byte_count(byte_count)
    );

    image_dump_uart_tx #(.CLKS_PER_BIT(CPB_S), .ADDR_W(16)) dut_slow (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .base_addr(base_addr_s),
        .length(length_s), .mem_addr(mem_addr_s), .mem_re(mem_re_s), .mem_dout(mem_dout_s),
        .tx(tx_s), .busy(busy_s), .done(done_s), .byte_count(byte_count_s)
    );

    int errors = 0;
    int checks = 0;

    int act_tx[$], exp_tx[$], act_busy[$], exp_busy[$];
    int act_re[$], exp_re[$], act_done[$], exp_done[$];

    function automatic int first_diff(input int a[$], input int b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    // Cycle index k = samples taken after the k-th edge following the accept edge (k=0 is FETCH).
    task automatic run_xfer(input logic [15:0] b, input logic [16:0] len, input int ncyc,
                            input int abort_at, input int start_at);
        act_tx.delete(); act_busy.delete(); act_re.delete(); act_done.delete();
        @(negedge clk);
        base_addr = b; length = len; start = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            act_tx.push_back(int'(tx));
            act_busy.push_back(int'(busy));
            if (mem_re) act_re.push_back((k << 16) | int'(mem_addr));
            if (done) act_done.push_back(k);
            start = (k == start_at);
            if (k == start_at) begin base_addr = 16'h1234; length = 17'd5; end
            abort = (k == abort_at);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    // Reference: each byte costs 2 idle-high cycles then a 10-bit frame {0, LSB..MSB, 1}.
    task automatic build_exp(input int b, input int len, input int ncyc, input int abort_at);
        exp_tx.delete(); exp_busy.delete(); exp_re.delete(); exp_done.delete();
        for (int i = 0; i < ncyc; i++) begin
            int j = i / BYTE_CYC;
            int o = i % BYTE_CYC;
            int t = 1;
            int bz = 0;
            int a = (b + j) % 65536;
            logic [7:0] d;
            if (!(abort_at >= 0 && i > abort_at) && j < len) begin
                bz = 1;
                d = mem[a];
                if (o < 2)               t = 1;
                else if (o < 2 + CPB)    t = 0;
                else if (o < 2 + 9*CPB)  t = int'(d[(o - 2 - CPB) / CPB]);
                else                     t = 1;
                if (o == 0) exp_re.push_back((i << 16) | a);
            end
            if (i == len * BYTE_CYC && abort_at < 0) exp_done.push_back(i);
            exp_tx.push_back(t);
            exp_busy.push_back(bz);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({tx, busy, done, mem_re, mem_addr, byte_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 17'h0}) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b re=%b addr=%h cnt=%0d, want 1 0 0 0 0000 0",
                     tx, busy, done, mem_re, mem_addr, byte_count);
        end
        checks++;
        if ({tx_s, busy_s, done_s, mem_re_s} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state_slow: tx/busy/done/re=%b want 1000", {tx_s, busy_s, done_s, mem_re_s});
        end
    endtask

    task automatic test_single_byte;
        int d;
        mem[16'h0010] = 8'hA5;
        run_xfer(16'h0010, 17'd1, BYTE_CYC + 3, -1, -1);
        build_exp(16'h0010, 1, BYTE_CYC + 3, -1);
        d = first_diff(act_tx, exp_tx); checks++;
        if (d != -1) begin errors++; $display("FAIL single_tx cycle %0d: got %0d want %0d", d, qat(act_tx, d), qat(exp_tx, d)); end
        d = first_diff(act_busy, exp_busy); checks++;
        if (d != -1) begin errors++; $display("FAIL single_busy cycle %0d: got %0d want %0d", d, qat(act_busy, d), qat(exp_busy, d)); end
        d = first_diff(act_re, exp_re); checks++;
        if (d != -1) begin errors++; $display("FAIL single_read #%0d: got %0h want %0h", d, qat(act_re, d), qat(exp_re, d)); end
        d = first_diff(act_done, exp_done); checks++;
        if (d != -1) begin errors++; $display("FAIL single_done #%0d: got cycle %0d want %0d", d, qat(act_done, d), qat(exp_done, d)); end
        checks++;
        if (byte_count !== 17'd1) begin errors++; $display("FAIL single_count: got %0d want 1", byte_count); end
    endtask

    task automatic test_back_to_back;
        int d;
        mem[16'h0100] = 8'h00; mem[16'h0101] = 8'hFF; mem[16'h0102] = 8'h3C;
        run_xfer(16'h0100, 17'd3, 3 * BYTE_CYC + 3, -1, 50);
        build_exp(16'h0100, 3, 3 * BYTE_CYC + 3, -1);
        d = first_diff(act_tx, exp_tx); checks++;
        if (d != -1) begin errors++; $display("FAIL b2b_tx cycle %0d: got %0d want %0d", d, qat(act_tx, d), qat(exp_tx, d)); end
        d = first_diff(act_busy, exp_busy); checks++;
        if (d != -1) begin errors++; $display("FAIL b2b_busy cycle %0d: got %0d want %0d", d, qat(act_busy, d), qat(exp_busy, d)); end
        d = first_diff(act_re, exp_re); checks++;
        if (d != -1) begin errors++; $display("FAIL b2b_read #%0d: got %0h want %0h", d, qat(act_re, d), qat(exp_re, d)); end
        d = first_diff(act_done, exp_done); checks++;
        if (d != -1) begin errors++; $display("FAIL b2b_done #%0d: got cycle %0d want %0d", d, qat(act_done, d), qat(exp_done, d)); end
        checks++;
        if (byte_count !== 17'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", byte_count); end
    endtask

    task automatic test_zero_length;
        int d;
        run_xfer(16'h0055, 17'd0, 6, -1, -1);
        build_exp(16'h0055, 0, 6, -1);
        d = first_diff(act_tx, exp_tx); checks++;
        if (d != -1) begin errors++; $display("FAIL zero_tx cycle %0d: got %0d want %0d", d, qat(act_tx, d), qat(exp_tx, d)); end
        d = first_diff(act_busy, exp_busy); checks++;
        if (d != -1) begin errors++; $display("FAIL zero_busy cycle %0d: got %0d want %0d", d, qat(act_busy, d), qat(exp_busy, d)); end
        checks++;
        if (act_re.size() != 0) begin errors++; $display("FAIL zero_read: got %0d reads want 0", act_re.size()); end
        d = first_diff(act_done, exp_done); checks++;
        if (d != -1) begin errors++; $display("FAIL zero_done #%0d: got cycle %0d want %0d", d, qat(act_done, d), qat(exp_done, d)); end
    endtask

    task automatic test_wrap;
        int d;
        mem[16'hFFFF] = 8'($urandom); mem[16'h0000] = 8'($urandom);
        run_xfer(16'hFFFF, 17'd2, 2 * BYTE_CYC + 3, -1, -1);
        build_exp(16'hFFFF, 2, 2 * BYTE_CYC + 3, -1);
        d = first_diff(act_tx, exp_tx); checks++;
        if (d != -1) begin errors++; $display("FAIL wrap_tx cycle %0d: got %0d want %0d", d, qat(act_tx, d), qat(exp_tx, d)); end
        d = first_diff(act_re, exp_re); checks++;
        if (d != -1) begin errors++; $display("FAIL wrap_read #%0d: got %0h want %0h", d, qat(act_re, d), qat(exp_re, d)); end
        d = first_diff(act_done, exp_done); checks++;
        if (d != -1) begin errors++; $display("FAIL wrap_done #%0d: got cycle %0d want %0d", d, qat(act_done, d), qat(exp_done, d)); end
        checks++;
        if (byte_count !== 17'd2) begin errors++; $display("FAIL wrap_count: got %0d want 2", byte_count); end
    endtask

    task automatic test_abort;
        int d;
        // Cycle 61 lies in data bit 3 of the second byte.
        run_xfer(16'hFFFF, 17'd2, 2 * BYTE_CYC + 3, 61, -1);
        build_exp(16'hFFFF, 2, 2 * BYTE_CYC + 3, 61);
        d = first_diff(act_tx, exp_tx); checks++;
        if (d != -1) begin errors++; $display("FAIL abort_tx cycle %0d: got %0d want %0d", d, qat(act_tx, d), qat(exp_tx, d)); end
        d = first_diff(act_busy, exp_busy); checks++;
        if (d != -1) begin errors++; $display("FAIL abort_busy cycle %0d: got %0d want %0d", d, qat(act_busy, d), qat(exp_busy, d)); end
        checks++;
        if (act_done.size() != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", act_done.size()); end
        checks++;
        if (byte_count !== 17'd1) begin errors++; $display("FAIL abort_count: got %0d want 1", byte_count); end
    endtask

    task automatic test_random;
        int d, b, len;
        for (int it = 0; it < 3; it++) begin
            b   = int'($urandom_range(0, 65535));
            len = int'($urandom_range(1, 3));
            for (int j = 0; j < len; j++) mem[(b + j) % 65536] = 8'($urandom);
            run_xfer(16'(b), 17'(len), len * BYTE_CYC + 3, -1, -1);
            build_exp(b, len, len * BYTE_CYC + 3, -1);
            d = first_diff(act_tx, exp_tx); checks++;
            if (d != -1) begin errors++; $display("FAIL rand%0d_tx cycle %0d: got %0d want %0d", it, d, qat(act_tx, d), qat(exp_tx, d)); end
            d = first_diff(act_re, exp_re); checks++;
            if (d != -1) begin errors++; $display("FAIL rand%0d_read #%0d: got %0h want %0h", it, d, qat(act_re, d), qat(exp_re, d)); end
            d = first_diff(act_done, exp_done); checks++;
            if (d != -1) begin errors++; $display("FAIL rand%0d_done #%0d: got cycle %0d want %0d", it, d, qat(act_done, d), qat(exp_done, d)); end
            checks++;
            if (byte_count !== 17'(len)) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, byte_count, len); end
        end
    endtask

    task automatic test_reset_mid_run;
        int bad = 0;
        mem[16'h0200] = 8'h00;
        run_xfer(16'h0200, 17'd1, 20, -1, -1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx, busy, done, mem_re} !== 4'b1000) begin
            errors++; $display("FAIL rst_async: tx/busy/done/re=%b want 1000", {tx, busy, done, mem_re});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if ({tx, busy, done, mem_re} !== 4'b1000) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_hold: got %0d non-idle cycles want 0", bad); end
        checks++;
        if (byte_count !== 17'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", byte_count); end
    endtask

    task automatic test_real_rate;
        int q[$];
        int done_at = -1, s = -1, p, v, run_len, bad_runs = 0;
        int ncyc = 2 + 10 * CPB_S + 6;
        logic [9:0] frame;
        mem_s[16'h0020] = 8'h55;
        @(negedge clk);
        base_addr_s = 16'h0020; length_s = 17'd1; start_s = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            start_s = 1'b0;
            q.push_back(int'(tx_s));
            if (done_s && done_at < 0) done_at = k;
        end
        for (int k = 0; k < q.size() && s < 0; k++) if (q[k] == 0) s = k;
        checks++;
        if (s != 2) begin errors++; $display("FAIL rate_start_edge: got cycle %0d want 2", s); end
        if (s >= 0) begin
            // 0x55 toggles every bit, so start..bit7 are nine runs of one bit period each.
            p = s;
            for (int r = 0; r < 9; r++) begin
                v = (p < q.size()) ? q[p] : -1;
                run_len = 0;
                while (p < q.size() && q[p] == v) begin run_len++; p++; end
                if (run_len != CPB_S) bad_runs++;
            end
            for (int i = 0; i < 10; i++) begin
                p = s + CPB_S / 2 + CPB_S * i;
                frame[i] = (p < q.size()) ? q[p][0] : 1'bx;
            end
        end else begin
            bad_runs = 9;
            frame = 'x;
        end
        checks++;
        if (bad_runs != 0) begin errors++; $display("FAIL rate_bit_period: got %0d bad periods want 0", bad_runs); end
        checks++;
        if (frame !== {1'b1, 8'h55, 1'b0}) begin errors++; $display("FAIL rate_decode: got frame %b want %b", frame, {1'b1, 8'h55, 1'b0}); end
        checks++;
        if (done_at != 2 + 10 * CPB_S) begin errors++; $display("FAIL rate_done: got cycle %0d want %0d", done_at, 2 + 10 * CPB_S); end
        checks++;
        if (byte_count_s !== 17'd1) begin errors++; $display("FAIL rate_count: got %0d want 1", byte_count_s); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_zero_length();
        test_wrap();
        test_abort();
        test_random();
        test_reset_mid_run();
        test_real_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
